// File: rtl/serial_digit_comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package cmp_pkg;

  localparam int unsigned DIGIT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Cascade seed: "everything so far is equal" before the least-significant digit
  localparam logic CASC_L0 = 1'b0;
  localparam logic CASC_E0 = 1'b1;
  localparam logic CASC_G0 = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_comparator_if.sv
// Request/result bundle between a compare requester and the serial comparator.
interface serial_digit_comparator_if #(
  parameter int unsigned WIDTH = 12
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (output start, a, b, input busy, done, lt, eq, gt);
  modport slave  (input start, a, b, output busy, done, lt, eq, gt);

endinterface

// File: rtl/serial_digit_comparator_comparator3.sv
// One 3-bit cascadable comparator slice; cascade inputs come from the less-significant side.
module comparator3
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               l_i,
  input  logic               e_i,
  input  logic               g_i,
  output logic               lt_o,
  output logic               eq_o,
  output logic               gt_o
);

  logic dig_eq;
  logic dig_gt;
  logic unused_l;

  // lt is derived from eq/gt, so the incoming lt cascade carries no extra information
  assign unused_l = l_i;

  assign dig_eq = (a_i == b_i);
  assign dig_gt = (a_i > b_i);

  assign eq_o = dig_eq & e_i;
  assign gt_o = dig_gt | (g_i & dig_eq);
  assign lt_o = ~(eq_o | gt_o);

endmodule

// File: rtl/serial_digit_comparator.sv
// Digit-serial unsigned magnitude comparator: one reused comparator3 slice walks
// the operands LSB digit first, carrying the cascade in registers.
module serial_digit_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_digit_comparator_if.slave bus
);

  localparam int unsigned DIGITS   = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W    = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if (((WIDTH % DIGIT_W) != 0) || (WIDTH < DIGIT_W)) begin : g_bad_width
      $error("serial_digit_comparator: WIDTH must be a positive multiple of 3");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cl_q, cl_d;
  logic             ce_q, ce_d;
  logic             cg_q, cg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic             s_lt;
  logic             s_eq;
  logic             s_gt;

  comparator3 u_slice (
    .a_i  (sa_q[DIGIT_W-1:0]),
    .b_i  (sb_q[DIGIT_W-1:0]),
    .l_i  (cl_q),
    .e_i  (ce_q),
    .g_i  (cg_q),
    .lt_o (s_lt),
    .eq_o (s_eq),
    .gt_o (s_gt)
  );

  // Next-state: capture on start in IDLE, one digit step per RUN cycle
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    cl_d    = cl_q;
    ce_d    = ce_q;
    cg_d    = cg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cl_d    = CASC_L0;
          ce_d    = CASC_E0;
          cg_d    = CASC_G0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cl_d  = s_lt;
        ce_d  = s_eq;
        cg_d  = s_gt;
        sa_d  = sa_q >> DIGIT_W;
        sb_d  = sb_q >> DIGIT_W;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          lt_d    = s_lt;
          eq_d    = s_eq;
          gt_d    = s_gt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      cl_q    <= 1'b0;
      ce_q    <= 1'b0;
      cg_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      cl_q    <= cl_d;
      ce_q    <= ce_d;
      cg_q    <= cg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;

endmodule

// File: tb/tb_serial_digit_comparator.sv
// Bench for serial_digit_comparator: arithmetic reference model checked every cycle
// plus directed scenarios with hand-computed results.
module tb_serial_digit_comparator;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned DIGITS = WIDTH / 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_digit_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_digit_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {lt, eq, gt} straight from unsigned arithmetic
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // Reference: a compare takes DIGITS edges, result held until the next completion
  int         m_rem  = 0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_res  = 3'b000;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end else if (bus.start) begin
        m_pend = ref_cmp(bus.a, bus.b);
        m_rem  = DIGITS;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] exp;
    got = {bus.busy, bus.done, bus.lt, bus.eq, bus.gt};
    exp = {(m_rem != 0), m_done, m_res};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model t=%0t busy/done/lt/eq/gt got %b want %b", $time, got, exp);
    end
    if (m_res != 3'b000) begin
      checks++;
      if ($countones({bus.lt, bus.eq, bus.gt}) != 1) begin
        errors++;
        $display("FAIL onehot t=%0t lt/eq/gt got %b want exactly one set", $time,
                 {bus.lt, bus.eq, bus.gt});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; returns on the next negedge with lat = 1
  task automatic start_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, output int lat);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_done(inout int lat);
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [WIDTH-1:0] ra, rb;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}), 32'd0);

    // 1: equal operands
    start_cmp(12'hABC, 12'hABC, lat);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("t1_latency", 32'(lat), 32'(DIGITS + 1));
    chk("t1_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b010);
    @(negedge clk);
    chk("t1_done_width", 32'(bus.done), 32'd0);

    // 2: MSB digit overrides LSB digit
    start_cmp(12'h400, 12'h001, lat);
    wait_done(lat);
    chk("t2_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b001);

    // 3: only the LSB digit differs
    start_cmp(12'h001, 12'h002, lat);
    wait_done(lat);
    chk("t3_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b100);

    // 4: start while busy is ignored; start in the done cycle is accepted
    start_cmp(12'h800, 12'h7FF, lat);
    chk("t4_hold_prev", 32'({bus.lt, bus.eq, bus.gt}), 32'b100);
    @(negedge clk);
    lat++;
    bus.start = 1'b1;
    bus.a     = 12'h000;
    bus.b     = 12'hFFF;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    wait_done(lat);
    chk("t4_latency", 32'(lat), 32'(DIGITS + 1));
    chk("t4_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b001);
    start_cmp(12'h123, 12'h124, lat);
    wait_done(lat);
    chk("t4_b2b_spacing", 32'(lat), 32'(DIGITS + 1));
    chk("t4_b2b_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b100);

    // 5: asynchronous reset mid-compare
    start_cmp(12'h005, 12'h006, lat);
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_reset", 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}), 32'd0);
    #4 rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("t5_no_done", 32'(pulses), 32'd0);

    // 6: random pairs, with spurious starts while busy
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom_range(0, 4095));
      rb = (i % 8 == 0) ? ra : WIDTH'($urandom_range(0, 4095));
      if (i % 16 == 1) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      start_cmp(ra, rb, lat);
      while (!bus.done && lat < 20) begin
        bus.start = bus.busy && ($urandom_range(0, 3) == 0);
        bus.a     = WIDTH'($urandom_range(0, 4095));
        bus.b     = WIDTH'($urandom_range(0, 4095));
        @(negedge clk);
        lat++;
      end
      bus.start = 1'b0;
      chk("rnd_latency", 32'(lat), 32'(DIGITS + 1));
      chk("rnd_result", 32'({bus.lt, bus.eq, bus.gt}), 32'(ref_cmp(ra, rb)));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_digit_comparator.md
Name: serial_digit_comparator

Overview:
- Sequential magnitude comparator for two WIDTH-bit unsigned operands.
- Walks the operands 3 bits (one digit) per clock, least-significant digit first.
- Each cycle it feeds one digit pair and the running cascade result through a single comparator3 slice, then registers the slice's lt/eq/gt as the cascade for the next, more-significant digit.
- It is the sequencing stage that drives comparator3: it replaces a wide parallel cascade with one reused slice.

Parameters:
- WIDTH, 12, operand width in bits. Must be a multiple of 3 and at least 3; any other value is an elaboration error.
- DIGITS, WIDTH/3, derived local constant: number of digit steps per compare.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare. Sampled only when idle.
- a  input  WIDTH  operand A. Captured on an accepted start.
- b  input  WIDTH  operand B. Captured on an accepted start.
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result is updated
- lt  output  1  registered result: A < B
- eq  output  1  registered result: A == B
- gt  output  1  registered result: A > B

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset rst_n is asynchronous, active-low.
  - On reset: state=IDLE; busy=0, done=0, lt=0, eq=0, gt=0; shift registers, digit counter and cascade registers all cleared.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge k captures a and b into shift registers sa and sb.
  - Same edge: cascade registers set to cl=0, ce=1, cg=0; counter cnt=0; busy=1; state=RUN.
  - start=0: no action, outputs hold.
- RUN, each edge:
  - The slice sees A=sa[2:0], B=sb[2:0], l=cl, e=ce, g=cg.
  - cl, ce and cg take the slice's lt, eq and gt.
  - sa and sb shift right by 3, zero-filled.
  - cnt increments.
- Slice function, which the digit step must match exactly:
  - eq = (digits equal) & e
  - gt = (digit A > digit B) | (g & digits equal)
  - lt = ~(eq | gt)
  - Input l is ignored by the slice.
- Completion:
  - On the RUN edge where cnt==DIGITS-1, the slice outputs load directly into lt, eq and gt.
  - Same edge: done=1, busy=0, state=IDLE.
  - Latency: start accepted at edge k; result and done are valid after edge k+DIGITS (DIGITS RUN edges).
- done:
  - Exactly one cycle wide.
  - Deasserts on the next edge unless a new compare completes there. That cannot happen when DIGITS>=1, because the minimum compare spacing is DIGITS+1 edges.
- Result hold:
  - lt, eq and gt change only at completion or reset.
  - They hold the previous result through a new compare.
- Exclusivity: after the first completion, exactly one of lt, eq and gt is 1.
- start while busy=1: ignored. No recapture, no restart.
- start in the cycle done=1: state is IDLE, so the compare is accepted. Back-to-back compares run every DIGITS+1 cycles.
- a and b changing during RUN: no effect, because operands are captured.
- rst_n low mid-compare: abort immediately (asynchronous). All outputs return to reset values; no done is produced.
- DIGITS=1: single RUN cycle; done follows start by one edge.

Decomposition:
- Shared package cmp_pkg:
  - DIGIT_W = 3
  - State enum {IDLE, RUN}
  - Cascade-init constants CASC_L0=0, CASC_E0=1, CASC_G0=0
- Sub-module: one instance of the existing comparator3 slice for the digit step.
- Counter width is $clog2(DIGITS) with a minimum of 1.

Test Plan:
All cases use WIDTH=12 (4 digits).
1. Reset, then a=12'hABC, b=12'hABC, start pulse → busy high 4 cycles, then done=1 with eq=1, lt=0, gt=0.
2. a=12'h400, b=12'h001 (LSB digit says less, MSB digit says greater) → after 4 cycles gt=1. Checks that the more-significant digit overrides.
3. a=12'h001, b=12'h002 (only the LSB digit differs) → lt=1. Also checks that eq=0 persists through the equal upper digits.
4. Start a=12'h800, b=12'h7FF; re-pulse start with a=0, b=FFF at cycle 2 → second start ignored; result gt=1 after the original 4 cycles. Then start again in the done cycle → accepted; next done 5 cycles after the first.
5. Start a compare, assert rst_n=0 at cycle 2 → busy, done, lt, eq, gt all 0 immediately. With rst_n released and no start, done never pulses.
6. Randomized 1000 pairs against a behavioural A<B / A==B / A>B model → results match, exactly one flag set, and every done comes exactly DIGITS edges after its accepted start.
